// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the digit-serial adder:
//   state_t   - controller states (IDLE, RUN, DONE)
//   cnt_width - width of the digit counter for a given number of digits;
//               never less than one bit, so the single-digit case still has
//               a legal counter.
// -----------------------------------------------------------------------------
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int cnt_width(input int n_digits);
      return (n_digits > 1) ? $clog2(n_digits) : 1;
   endfunction

endpackage

// File: rtl/digit_adder.sv
// -----------------------------------------------------------------------------
// digit_adder
// Combinational DIGIT-bit slice adder used once per cycle by the serial adder.
//   a_d, b_d : slice operands (b already inverted for subtraction)
//   ci       : carry into the slice
//   s_d      : slice sum
//   co       : carry out of the slice's top bit
//   c_msb    : carry into the slice's top bit (for signed overflow)
// -----------------------------------------------------------------------------
module digit_adder #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a_d,
   input  logic [DIGIT-1:0] b_d,
   input  logic             ci,
   output logic [DIGIT-1:0] s_d,
   output logic             co,
   output logic             c_msb
);

   logic [DIGIT:0] sum;

   always_comb begin
      sum = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT{1'b0}}, ci};
   end

   assign s_d = sum[DIGIT-1:0];
   assign co  = sum[DIGIT];
   // The sum bit is a^b^carry_in, so the carry into the top bit falls out
   // by XOR-ing the operand bits back off.
   assign c_msb = a_d[DIGIT-1] ^ b_d[DIGIT-1] ^ sum[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// -----------------------------------------------------------------------------
// digit_serial_adder
// Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, least
// significant slice first. Result, carry-out and signed overflow are
// published together when the last slice completes and held until the next
// completion.
//   clk, rst : clock, asynchronous active-high reset
//   start    : operation request, accepted only when idle
//   sub      : 0 = a+b+cin, 1 = a-b-cin
//   a, b     : operands, sampled only when start is accepted
//   cin      : carry-in (add) / borrow-in (subtract)
//   busy     : operation in progress (RUN or DONE)
//   done     : one-cycle completion pulse
//   s        : result modulo 2^WIDTH
//   cout     : carry-out; for subtract 1 means no borrow
//   ovf      : two's-complement overflow
// -----------------------------------------------------------------------------
module digit_serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int            N    = WIDTH / DIGIT;
   localparam int            CW   = cnt_width(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] op_a_q, op_a_d;
   logic [WIDTH-1:0] op_b_q, op_b_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   int               base;
   logic [DIGIT-1:0] sl_a, sl_b, sl_s;
   logic             sl_co, sl_cmsb;

   // Bit offset of the slice being worked on this cycle.
   assign base = int'(cnt_q) * DIGIT;
   assign sl_a = op_a_q[base +: DIGIT];
   assign sl_b = op_b_q[base +: DIGIT];

   digit_adder #(
      .DIGIT (DIGIT)
   ) u_slice (
      .a_d   (sl_a),
      .b_d   (sl_b),
      .ci    (carry_q),
      .s_d   (sl_s),
      .co    (sl_co),
      .c_msb (sl_cmsb)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      carry_d = carry_q;
      acc_d   = acc_q;
      res_d   = res_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               op_a_d  = a;
               // Subtraction is a + ~b + 1; the borrow-in removes that +1.
               op_b_d  = sub ? ~b : b;
               carry_d = cin ^ sub;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d[base +: DIGIT] = sl_s;
            carry_d              = sl_co;
            cnt_d                = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               res_d                = acc_q;
               res_d[base +: DIGIT] = sl_s;
               cout_d               = sl_co;
               ovf_d                = sl_co ^ sl_cmsb;
               state_d              = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         carry_q <= 1'b0;
         acc_q   <= '0;
         res_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         carry_q <= carry_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign s    = res_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_digit_serial_adder
// Bench for digit_serial_adder: a 16-bit/4-bit-digit instance and an
// 8-bit/8-bit-digit instance share clock and reset. Expected results come
// from plain integer arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_digit_serial_adder;

   localparam int N16 = 4;
   localparam int N8  = 1;

   logic        clk = 1'b0;
   logic        rst;

   logic        start16, sub16, cin16;
   logic [15:0] a16, b16, s16;
   logic        busy16, done16, cout16, ovf16;

   logic        start8, sub8, cin8;
   logic [7:0]  a8, b8, s8;
   logic        busy8, done8, cout8, ovf8;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16),
      .cin(cin16), .busy(busy16), .done(done16), .s(s16), .cout(cout16),
      .ovf(ovf16)
   );

   digit_serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
      .cin(cin8), .busy(busy8), .done(done8), .s(s8), .cout(cout8),
      .ovf(ovf8)
   );

   // Reference: exact integer add/subtract, carry as "result left the
   // unsigned range", overflow as "signed result left the signed range".
   function automatic void ref_op(input int w, input longint ua, input longint ub,
                                  input bit sb, input bit ci,
                                  output longint rs, output bit rc, output bit ro);
      longint m, full, sa, sbv, sr;
      m = longint'(1) << w;
      if (!sb) begin
         full = ua + ub + longint'(ci);
         rc   = (full >= m);
      end else begin
         full = ua - ub - longint'(ci);
         rc   = (full >= 0);
      end
      rs  = (full + m) % m;
      sa  = (ua >= m / 2) ? ua - m : ua;
      sbv = (ub >= m / 2) ? ub - m : ub;
      sr  = sb ? (sa - sbv - longint'(ci)) : (sa + sbv + longint'(ci));
      ro  = (sr > m / 2 - 1) || (sr < -(m / 2));
   endfunction

   // Issue one operation and observe a fixed window of cycles after the
   // accepting edge. lat is the first sample (edges after acceptance) with
   // done high; hold_ok says s kept its old value until then.
   task automatic do_op(input bit w8, input logic [15:0] ia, input logic [15:0] ib,
                        input bit isub, input bit icin, input int window,
                        output int lat, output int busy_cnt, output int ndone,
                        output bit hold_ok, output logic [15:0] rs,
                        output logic rc, output logic ro);
      logic [15:0] prev;
      logic        bz, dn;
      logic [15:0] cur;
      @(negedge clk);
      rst  = 1'b0;
      prev = w8 ? {8'h00, s8} : s16;
      if (w8) begin
         a8 = ia[7:0]; b8 = ib[7:0]; sub8 = isub; cin8 = icin; start8 = 1'b1;
      end else begin
         a16 = ia; b16 = ib; sub16 = isub; cin16 = icin; start16 = 1'b1;
      end
      @(posedge clk); #1;
      start16 = 1'b0;
      start8  = 1'b0;
      // Operands are don't-care after acceptance; scramble them.
      a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom); cin16 = 1'($urandom);
      a8  = 8'($urandom);  b8  = 8'($urandom);  sub8  = 1'($urandom); cin8  = 1'($urandom);
      lat      = -1;
      ndone    = 0;
      hold_ok  = 1'b1;
      busy_cnt = (w8 ? busy8 : busy16) ? 1 : 0;
      for (int k = 1; k <= window; k++) begin
         @(posedge clk); #1;
         bz  = w8 ? busy8 : busy16;
         dn  = w8 ? done8 : done16;
         cur = w8 ? {8'h00, s8} : s16;
         if (bz) busy_cnt++;
         if (dn) begin
            ndone++;
            if (lat < 0) lat = k;
         end
         if (lat < 0 && cur !== prev) hold_ok = 1'b0;
      end
      rs = w8 ? {8'h00, s8} : s16;
      rc = w8 ? cout8 : cout16;
      ro = w8 ? ovf8 : ovf16;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start16 = 1'b0; sub16 = 1'b0; cin16 = 1'b0; a16 = '0; b16 = '0;
      start8  = 1'b0; sub8  = 1'b0; cin8  = 1'b0; a8  = '0; b8  = '0;
      repeat (2) @(posedge clk);
      #1;
      n_tests++; if (busy16 !== 1'b0) begin n_fail++; $display("FAIL reset_busy16 got %b want 0", busy16); end
      n_tests++; if (done16 !== 1'b0) begin n_fail++; $display("FAIL reset_done16 got %b want 0", done16); end
      n_tests++; if (s16 !== 16'h0000) begin n_fail++; $display("FAIL reset_s16 got %h want 0000", s16); end
      n_tests++; if (cout16 !== 1'b0) begin n_fail++; $display("FAIL reset_cout16 got %b want 0", cout16); end
      n_tests++; if (ovf16 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf16 got %b want 0", ovf16); end
      n_tests++; if ({busy8, done8, s8, cout8, ovf8} !== 12'h000) begin
         n_fail++; $display("FAIL reset_dut8 got %h want 000", {busy8, done8, s8, cout8, ovf8});
      end
   endtask

   typedef struct {
      logic [15:0] a, b;
      bit          sb, ci;
      logic [15:0] s;
      bit          c, o;
   } vec_t;

   task automatic test_directed();
      vec_t vecs [4];
      int lat, bc, nd;
      bit hold;
      logic [15:0] rs;
      logic rc, ro;
      vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[2] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
      vecs[3] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
      for (int i = 0; i < 4; i++) begin
         do_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].sb, vecs[i].ci, N16 + 3,
               lat, bc, nd, hold, rs, rc, ro);
         n_tests++; if (rs !== vecs[i].s) begin n_fail++; $display("FAIL dir%0d_s got %h want %h", i, rs, vecs[i].s); end
         n_tests++; if (rc !== vecs[i].c) begin n_fail++; $display("FAIL dir%0d_cout got %b want %b", i, rc, vecs[i].c); end
         n_tests++; if (ro !== vecs[i].o) begin n_fail++; $display("FAIL dir%0d_ovf got %b want %b", i, ro, vecs[i].o); end
         if (i == 0) begin
            // Done visible after the Nth edge following acceptance; busy
            // covers N RUN cycles plus the DONE cycle.
            n_tests++; if (lat !== N16) begin n_fail++; $display("FAIL dir_latency got %0d want %0d", lat, N16); end
            n_tests++; if (bc !== N16 + 1) begin n_fail++; $display("FAIL dir_busy_cycles got %0d want %0d", bc, N16 + 1); end
            n_tests++; if (nd !== 1) begin n_fail++; $display("FAIL dir_done_pulses got %0d want 1", nd); end
         end
      end
   endtask

   task automatic test_random(input bit w8, input int iters);
      int lat, bc, nd, w, n;
      bit hold, sb, ci, ec, eo;
      logic [15:0] ua, ub, rs;
      logic rc, ro;
      longint es;
      w = w8 ? 8 : 16;
      n = w8 ? N8 : N16;
      for (int i = 0; i < iters; i++) begin
         ua = 16'($urandom);
         ub = 16'($urandom);
         if (w8) begin ua[15:8] = 8'h00; ub[15:8] = 8'h00; end
         sb = 1'($urandom);
         ci = 1'($urandom);
         ref_op(w, longint'(ua), longint'(ub), sb, ci, es, ec, eo);
         do_op(w8, ua, ub, sb, ci, n + 2, lat, bc, nd, hold, rs, rc, ro);
         n_tests++; if (rs !== 16'(es)) begin n_fail++; $display("FAIL rnd%0d_w%0d_s a=%h b=%h sub=%b cin=%b got %h want %h", i, w, ua, ub, sb, ci, rs, 16'(es)); end
         n_tests++; if (rc !== ec) begin n_fail++; $display("FAIL rnd%0d_w%0d_cout got %b want %b", i, w, rc, ec); end
         n_tests++; if (ro !== eo) begin n_fail++; $display("FAIL rnd%0d_w%0d_ovf got %b want %b", i, w, ro, eo); end
         n_tests++; if (lat !== n) begin n_fail++; $display("FAIL rnd%0d_w%0d_latency got %0d want %0d", i, w, lat, n); end
         n_tests++; if (nd !== 1) begin n_fail++; $display("FAIL rnd%0d_w%0d_done_pulses got %0d want 1", i, w, nd); end
         n_tests++; if (hold !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_w%0d_hold got %b want 1", i, w, hold); end
      end
   endtask

   task automatic test_ignore_start();
      int ndone, lat;
      @(negedge clk);
      a16 = 16'h1234; b16 = 16'h1111; sub16 = 1'b0; cin16 = 1'b0; start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      ndone = 0;
      lat   = -1;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         if (done16) begin
            ndone++;
            if (lat < 0) lat = k;
         end
         // A second request with different operands, seen at edge 2.
         if (k == 1) begin
            start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF; sub16 = 1'b1; cin16 = 1'b1;
         end
         if (k == 2) start16 = 1'b0;
      end
      n_tests++; if (s16 !== 16'h2345) begin n_fail++; $display("FAIL ignore_s got %h want 2345", s16); end
      n_tests++; if (ndone !== 1) begin n_fail++; $display("FAIL ignore_done_pulses got %0d want 1", ndone); end
      n_tests++; if (lat !== N16) begin n_fail++; $display("FAIL ignore_latency got %0d want %0d", lat, N16); end
      n_tests++; if (busy16 !== 1'b0) begin n_fail++; $display("FAIL ignore_idle_after got %b want 0", busy16); end
   endtask

   task automatic test_reset_mid_run();
      int lat, bc, nd;
      bit hold;
      logic [15:0] rs;
      logic rc, ro;
      @(negedge clk);
      a16 = 16'h1111; b16 = 16'h2222; sub16 = 1'b0; cin16 = 1'b0; start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      // Now in the third RUN cycle; reset must act without a clock edge.
      rst = 1'b1;
      #1;
      n_tests++; if (busy16 !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy16); end
      n_tests++; if (done16 !== 1'b0) begin n_fail++; $display("FAIL midrst_done got %b want 0", done16); end
      n_tests++; if (s16 !== 16'h0000) begin n_fail++; $display("FAIL midrst_s got %h want 0000", s16); end
      n_tests++; if ({cout16, ovf16} !== 2'b00) begin n_fail++; $display("FAIL midrst_flags got %b want 00", {cout16, ovf16}); end
      @(posedge clk);
      // Reset is released on the same negedge that presents the new start.
      do_op(1'b0, 16'h0001, 16'h0001, 1'b0, 1'b0, N16 + 4, lat, bc, nd, hold, rs, rc, ro);
      n_tests++; if (rs !== 16'h0002) begin n_fail++; $display("FAIL postrst_s got %h want 0002", rs); end
      n_tests++; if (lat !== N16) begin n_fail++; $display("FAIL postrst_latency got %0d want %0d", lat, N16); end
      n_tests++; if (bc !== N16 + 1) begin n_fail++; $display("FAIL postrst_busy_cycles got %0d want %0d", bc, N16 + 1); end
      n_tests++; if (nd !== 1) begin n_fail++; $display("FAIL postrst_done_pulses got %0d want 1", nd); end
   endtask

   task automatic test_single_digit();
      int lat, bc, nd;
      bit hold;
      logic [15:0] rs;
      logic rc, ro;
      do_op(1'b1, 16'h0080, 16'h0080, 1'b0, 1'b1, N8 + 3, lat, bc, nd, hold, rs, rc, ro);
      n_tests++; if (rs !== 16'h0001) begin n_fail++; $display("FAIL n1_s got %h want 0001", rs); end
      n_tests++; if (rc !== 1'b1) begin n_fail++; $display("FAIL n1_cout got %b want 1", rc); end
      n_tests++; if (ro !== 1'b1) begin n_fail++; $display("FAIL n1_ovf got %b want 1", ro); end
      n_tests++; if (lat !== N8) begin n_fail++; $display("FAIL n1_latency got %0d want %0d", lat, N8); end
      n_tests++; if (bc !== N8 + 1) begin n_fail++; $display("FAIL n1_busy_cycles got %0d want %0d", bc, N8 + 1); end
      n_tests++; if (nd !== 1) begin n_fail++; $display("FAIL n1_done_pulses got %0d want 1", nd); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random(1'b0, 40);
      test_ignore_start();
      test_reset_mid_run();
      test_single_digit();
      test_random(1'b1, 20);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
